// File: rtl/e_mdu_if.sv
// e_mdu_if: operand, control and HI/LO result bundle between the E stage and the multiply/divide unit (MDU_DIV0_KEEP_EN adds div0)
interface e_mdu_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  mdOp;
    logic        hiSel;
    logic        req;
    logic        start;
    logic        busy;
    logic [31:0] mdOut;
    logic [31:0] HI;
    logic [31:0] LO;
`ifdef MDU_DIV0_KEEP_EN
    logic        div0;
`endif
    modport slave (
        input  A, B, mdOp, hiSel, req,
`ifdef MDU_DIV0_KEEP_EN
        output div0,
`endif
        output start, busy, mdOut, HI, LO
    );
    modport master (
        output A, B, mdOp, hiSel, req,
`ifdef MDU_DIV0_KEEP_EN
        input  div0,
`endif
        input  start, busy, mdOut, HI, LO
    );
endinterface

// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit with HI/LO and busy-counter latency (MDU_DIV0_KEEP_EN keeps HI/LO on divide by zero and adds div0)
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic   clk,
    input logic   reset,
    e_mdu_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t      state;
    logic [3:0]  count;
    logic [31:0] temp_hi, temp_lo;
    logic [63:0] prod_s, prod_u;
    logic [31:0] num, den, quo, rem, res_hi, res_lo;
    logic        is_mult, is_div, sdiv, b_zero;
`ifdef MDU_DIV0_KEEP_EN
    logic        temp_div0;
`endif
    assign is_mult   = bus.mdOp == 3'd1 || bus.mdOp == 3'd2;
    assign is_div    = bus.mdOp == 3'd3 || bus.mdOp == 3'd4;
    assign bus.start = (is_mult || is_div) && !bus.req && !bus.busy;
    assign bus.mdOut = bus.hiSel ? bus.HI : bus.LO;
    // Full result for the op on the inputs; signed divide works on magnitudes and fixes signs afterwards
    always_comb begin
        sdiv   = bus.mdOp == 3'd3;
        b_zero = bus.B == 32'd0;
        prod_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
        prod_u = {32'd0, bus.A} * {32'd0, bus.B};
        num    = sdiv && bus.A[31] ? -bus.A : bus.A;
        den    = b_zero ? 32'd1 : (sdiv && bus.B[31] ? -bus.B : bus.B);
        quo    = num / den;
        rem    = num % den;
        res_hi = bus.mdOp == 3'd1 ? prod_s[63:32] :
                 bus.mdOp == 3'd2 ? prod_u[63:32] :
                 b_zero ? bus.A : (sdiv && bus.A[31] ? -rem : rem);
        res_lo = bus.mdOp == 3'd1 ? prod_s[31:0] :
                 bus.mdOp == 3'd2 ? prod_u[31:0] :
                 b_zero ? 32'hFFFF_FFFF : (sdiv && (bus.A[31] ^ bus.B[31]) ? -quo : quo);
    end
    // IDLE/RUN control: capture result at start, count down, commit to HI/LO on the last busy cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= '0;
            bus.busy <= 1'b0;
            bus.HI   <= '0;
            bus.LO   <= '0;
            temp_hi  <= '0;
            temp_lo  <= '0;
`ifdef MDU_DIV0_KEEP_EN
            temp_div0 <= 1'b0;
            bus.div0  <= 1'b0;
`endif
        end else if (state == IDLE) begin
            if (bus.start) begin
                temp_hi  <= res_hi;
                temp_lo  <= res_lo;
                count    <= is_mult ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                state    <= RUN;
                bus.busy <= 1'b1;
`ifdef MDU_DIV0_KEEP_EN
                temp_div0 <= is_div && b_zero;
                bus.div0  <= 1'b0;
`endif
            end else if (!bus.req && bus.mdOp == 3'd5) begin
                bus.HI <= bus.A;
            end else if (!bus.req && bus.mdOp == 3'd6) begin
                bus.LO <= bus.A;
            end
        end else begin
            count <= count - 4'd1;
            if (count == 4'd1) begin
                state    <= IDLE;
                bus.busy <= 1'b0;
`ifdef MDU_DIV0_KEEP_EN
                if (temp_div0) begin
                    bus.div0 <= 1'b1;
                end else begin
                    bus.HI <= temp_hi;
                    bus.LO <= temp_lo;
                end
`else
                bus.HI <= temp_hi;
                bus.LO <= temp_lo;
`endif
            end
        end
    end
endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: randomized and directed checks of e_mdu against an arithmetic reference model
module tb_e_mdu;
    localparam int MC = 5;
    localparam int DC = 10;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;
    logic exp_div0 = 1'b0;
    e_mdu_if bus();
    e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] h, output logic [31:0] l, output logic z);
        longint sa, sb;
        logic [63:0] p;
        h = exp_hi;
        l = exp_lo;
        z = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd1: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
            3'd2: begin p = {32'd0, a} * {32'd0, b}; h = p[63:32]; l = p[31:0]; end
            3'd3, 3'd4: begin
                if (b == 0) begin
                    z = 1'b1;
`ifndef MDU_DIV0_KEEP_EN
                    h = a;
                    l = 32'hFFFF_FFFF;
`endif
                end else if (op == 3'd3) begin
                    h = 32'(sa % sb);
                    l = 32'(sa / sb);
                end else begin
                    h = a % b;
                    l = a / b;
                end
            end
            3'd5: h = a;
            3'd6: l = a;
            default: ;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic r);
        logic [31:0] nh, nl;
        logic z, go, hs;
        int cnt;
        @(negedge clk);
        hs = 1'($urandom_range(0, 1));
        bus.mdOp = op; bus.A = a; bus.B = b; bus.req = r; bus.hiSel = hs;
        #1;
        go = (op >= 3'd1 && op <= 3'd4) && !r;
        check("start", 64'(bus.start), 64'(go));
        check("mdout_pre", 64'(bus.mdOut), 64'(hs ? exp_hi : exp_lo));
        ref_md(op, a, b, nh, nl, z);
        @(posedge clk);
        #1;
        bus.mdOp = 3'd0; bus.req = 1'b0;
        if (go) begin
            cnt = 0;
            while (bus.busy && cnt < 40) begin
                cnt++;
                check("hi_hold", 64'(bus.HI), 64'(exp_hi));
                check("lo_hold", 64'(bus.LO), 64'(exp_lo));
                bus.mdOp = 3'($urandom_range(1, 6));
                bus.A = $urandom; bus.B = $urandom;
                #1;
                check("start_busy", 64'(bus.start), 64'd0);
                @(posedge clk);
                #1;
            end
            bus.mdOp = 3'd0;
            check("busy_len", 64'(cnt), 64'((op <= 3'd2) ? MC : DC));
            exp_div0 = z;
        end
        if (!r) begin
            exp_hi = nh;
            exp_lo = nl;
        end
        check("busy_idle", 64'(bus.busy), 64'd0);
        check("hi", 64'(bus.HI), 64'(exp_hi));
        check("lo", 64'(bus.LO), 64'(exp_lo));
        check("mdout", 64'(bus.mdOut), 64'(hs ? exp_hi : exp_lo));
`ifdef MDU_DIV0_KEEP_EN
        check("div0", 64'(bus.div0), 64'(exp_div0));
`endif
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bus.A = '0; bus.B = '0; bus.mdOp = 3'd0; bus.hiSel = 1'b0; bus.req = 1'b0;
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_hi", 64'(bus.HI), 64'd0);
        check("rst_lo", 64'(bus.LO), 64'd0);
        check("rst_start", 64'(bus.start), 64'd0);
        #12 reset = 1'b1;
        run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(3'd4, 32'd5, 32'd0, 1'b0);
        run_op(3'd5, 32'h1234_5678, 32'd0, 1'b0);
        run_op(3'd5, 32'hDEAD_BEEF, 32'd0, 1'b1);
        run_op(3'd6, 32'hCAFE_F00D, 32'd0, 1'b0);
        run_op(3'd1, 32'd3, 32'd4, 1'b1);
        for (int i = 0; i < 60; i++)
            run_op(3'($urandom_range(0, 7)), pick(), pick(), $urandom_range(0, 3) == 0);
        @(negedge clk);
        bus.mdOp = 3'd3; bus.A = 32'd100; bus.B = 32'd7; bus.req = 1'b0;
        @(posedge clk);
        #1;
        bus.mdOp = 3'd0;
        repeat (3) @(posedge clk);
        #2;
        check("mid_busy", 64'(bus.busy), 64'd1);
        reset = 1'b0;
        #1;
        check("async_busy", 64'(bus.busy), 64'd0);
        check("async_hi", 64'(bus.HI), 64'd0);
        check("async_lo", 64'(bus.LO), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        exp_hi = '0; exp_lo = '0; exp_div0 = 1'b0;
        repeat (DC) @(posedge clk);
        #1;
        check("post_rst_hi", 64'(bus.HI), 64'd0);
        check("post_rst_busy", 64'(bus.busy), 64'd0);
        run_op(3'd4, 32'd100, 32'd7, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Execute-stage multiply/divide unit, fed by the decode controller's MD-class decode (mult, multu, div, divu, mfhi, mflo, mthi, mtlo) after it is pipelined into E.
- Owns architectural HI/LO, models multi-cycle latency with a busy counter, and drives `start`/`busy` to the hazard unit so D-stage MD instructions stall.
- Supplies HI/LO read data for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- A  input  32  forwarded rs value.
- B  input  32  forwarded rt value.
- mdOp  input  3  operation code:
  - 0 none
  - 1 mult
  - 2 multu
  - 3 div
  - 4 divu
  - 5 mthi
  - 6 mtlo
  - 7 none (reserved)
- hiSel  input  1  read select: 1 = HI, 0 = LO.
- req  input  1  exception/interrupt request in flight; squashes the E-stage MD op this cycle.
- start  output  1  combinational: mdOp in {1,2,3,4} and !req and !busy.
- busy  output  1  registered; operation in progress.
- mdOut  output  32  hiSel ? HI : LO; combinational from the registers.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.

Behaviour:
- Reset: asynchronous, active-low; all values below take effect immediately.
  - HI=0, LO=0, busy=0.
  - Counter=0, state IDLE.
  - Temp result registers = 0.
  - div0 flag = 0 (when the optional feature is built).
- States: IDLE, RUN.
- IDLE, start=1 at edge t0:
  - Compute the full result into tempHi/tempLo at t0.
  - Load counter = MULT_CYCLES or DIV_CYCLES.
  - Go to RUN; busy=1 from t0+1.
- RUN:
  - Counter decrements each edge.
  - At the edge where counter==1: HI<=tempHi, LO<=tempLo, busy<=0, state IDLE.
  - busy is therefore high for exactly N cycles (t0+1..t0+N); new HI/LO are visible in cycle t0+N+1.
- mthi/mtlo:
  - Accepted only in IDLE with !req.
  - Single-cycle write at the next edge; busy is not raised.
- Arithmetic:
  - mult: signed 32x32 to 64; HI = bits [63:32], LO = bits [31:0].
  - multu: unsigned 32x32 to 64; same split.
  - div: signed; LO = quotient truncated toward zero; HI = remainder carrying the sign of the dividend.
  - 0x80000000 div 0xFFFFFFFF: LO=0x80000000, HI=0, no trap.
  - divu: unsigned; LO = A/B, HI = A%B.
  - Divide by zero: see Optional Feature.
- req=1 squashes the current E-stage op: no start, no mthi/mtlo write.
  - An operation already in RUN is never aborted by req; it belongs to an older committed instruction and completes normally.
- mdOp in {1..6} while busy=1:
  - Must not occur; the hazard unit stalls D when D is MD and (start||busy).
  - The block ignores it: no state change, start=0.
- mdOut and HI/LO always reflect committed registers, never temp values.
- Reset asserted mid-RUN: busy drops to 0 immediately, the pending result is discarded, HI/LO = 0.

Optional Feature:
- Macro: MDU_DIV0_KEEP_EN.
- Defined:
  - div/divu with B==0 leaves HI/LO unchanged at completion.
  - Busy timing is unchanged (still DIV_CYCLES).
  - Adds output `div0` (1 bit): sticky flag set at completion of a divide-by-zero, cleared by reset or by the next accepted start.
- Undefined:
  - Divide by zero commits HI=A, LO=0xFFFFFFFF.
  - No `div0` port exists.

Test Plan:
- Reset then mult A=0xFFFFFFFE(-2), B=3 → start=1 one cycle; busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu A=0xFFFFFFFF, B=2 → after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE; HI/LO hold old values throughout busy.
- div A=0xFFFFFFF9(-7), B=2 → busy 10 cycles; LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1).
- div A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- divu A=5, B=0:
  - Macro off → HI=5, LO=0xFFFFFFFF.
  - Macro on → HI/LO unchanged, div0=1.
- Control sequence:
  - mthi A=0x12345678 with req=0 → HI=0x12345678 next cycle, busy stays 0; mdOut=0x12345678 with hiSel=1.
  - Same mthi with req=1 → HI unchanged.
  - mult issued with req=1 → start=0, busy stays 0.
  - reset asserted during div busy → busy=0 at once, HI=LO=0.
